// File: rtl/pmu_pkg.sv
// Shared constants, state encoding and command helpers for the power-manager command front-end.
package pmu_pkg;

  localparam logic [2:0] MODE_PLL = 3'b000;
  localparam logic [2:0] MODE_CLK = 3'b001;
  localparam logic [2:0] MODE_FR1 = 3'b010;
  localparam logic [2:0] MODE_FR2 = 3'b011;
  localparam logic [2:0] MODE_FR3 = 3'b100;

  localparam int unsigned MASK_CLK1_BIT = 7;
  localparam int unsigned MASK_CLK2_BIT = 6;
  localparam int unsigned MASK_CLK3_BIT = 5;

  localparam logic [2:0] SHADOW1_RST = MODE_CLK;
  localparam logic [2:0] SHADOW2_RST = MODE_FR2;
  localparam logic [2:0] SHADOW3_RST = MODE_PLL;

  localparam logic [7:0] SLEEP_VECTOR = 8'hE2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StSettle
  } pmu_state_e;

  function automatic logic mode_legal(input logic [2:0] mode);
    return mode <= MODE_FR3;
  endfunction

  // Reserved bits [4:3] never reach the power manager.
  function automatic logic [7:0] sanitize_cmd(input logic [7:0] cmd);
    return {cmd[7:5], 2'b00, cmd[2:0]};
  endfunction

endpackage

// File: rtl/pmu_cmd_ctrl_if.sv
// CPU I/O port, wake input and power-manager change/status signals of pmu_cmd_ctrl.
interface pmu_cmd_ctrl_if;

  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       wake;
  logic       busy;
  logic       err;
  logic       change;
  logic [7:0] change_vector;

  modport master (
    output io_wr, io_rd, io_addr, io_wdata, wake,
    input  io_rdata, busy, err, change, change_vector
  );

  modport slave (
    input  io_wr, io_rd, io_addr, io_wdata, wake,
    output io_rdata, busy, err, change, change_vector
  );

endinterface

// File: rtl/pmu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; push when full and pop when empty are ignored.
module pmu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pmu_cmd_ctrl.sv
// Power-manager command front-end: I/O port decode, command FIFO, issue/settle FSM, clock shadow.
// Optional auto-sleep with restore is enabled by defining PMU_AUTO_SLEEP_EN.
module pmu_cmd_ctrl
  import pmu_pkg::*;
#(
  parameter logic [7:0]  CMD_ADDR      = 8'hF0,
  parameter logic [7:0]  STAT_ADDR     = 8'hF1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [23:0] IDLE_CYCLES   = 24'd12000000
) (
  input logic         clk,
  input logic         reset,
  pmu_cmd_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  pmu_state_e      state_q, state_d;
  logic [7:0]      settle_q, settle_d;
  logic [7:0]      vec_q, vec_d;
  logic            change_q, change_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [2:0][2:0] shadow_q, shadow_d;

  logic            wr_cmd, rd_stat, mode_ok, mask_ok;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic [4:0]      count_ext;
  logic [2:0]      count_sat;
  logic            new_err, busy, sleeping;
  logic            pick_point, fifo_ok, take;
  logic            int_valid;
  logic [7:0]      int_vec, next_vec;

  assign wr_cmd    = bus.io_wr && (bus.io_addr == CMD_ADDR);
  assign rd_stat   = bus.io_rd && (bus.io_addr == STAT_ADDR);
  assign mode_ok   = mode_legal(bus.io_wdata[2:0]);
  assign mask_ok   = bus.io_wdata[7:5] != 3'b000;
  // Mode check wins over the mask check: an illegal mode always flags err.
  assign fifo_push = wr_cmd && mode_ok && mask_ok && !fifo_full;
  assign new_err   = wr_cmd && (!mode_ok || (mask_ok && fifo_full));

  pmu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (sanitize_cmd(bus.io_wdata)),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign count_ext  = 5'(fifo_count);
  assign count_sat  = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];

  // A new command may start from IDLE or on the last SETTLE cycle, so pulses are back to back.
  assign pick_point = (state_q == StIdle) || ((state_q == StSettle) && (settle_q == 8'd0));
  assign fifo_ok    = !fifo_empty && !sleeping;
  assign take       = pick_point && (int_valid || fifo_ok);
  assign fifo_pop   = pick_point && !int_valid && fifo_ok;
  assign next_vec   = int_valid ? int_vec : fifo_rdata;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    change_d = 1'b0;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
      end
      StIssue: begin
        if (vec_q[MASK_CLK1_BIT]) shadow_d[0] = vec_q[2:0];
        if (vec_q[MASK_CLK2_BIT]) shadow_d[1] = vec_q[2:0];
        if (vec_q[MASK_CLK3_BIT]) shadow_d[2] = vec_q[2:0];
        settle_d = 8'(SETTLE_CYCLES - 1);
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q != 8'd0) settle_d = settle_q - 8'd1;
        else                  state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      vec_d    = next_vec;
      change_d = 1'b1;
      state_d  = StIssue;
    end
  end

  always_comb begin
    err_d = err_q;
    if (new_err)      err_d = 1'b1;
    else if (rd_stat) err_d = 1'b0;
    rdata_d = 8'h00;
    if (rd_stat) rdata_d = {busy, fifo_full, fifo_empty, err_q, sleeping, count_sat};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      settle_q <= 8'd0;
      vec_q    <= 8'h00;
      change_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 8'h00;
      shadow_q <= {SHADOW3_RST, SHADOW2_RST, SHADOW1_RST};
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      change_q <= change_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef PMU_AUTO_SLEEP_EN
  logic [23:0]     idle_q;
  logic            sleeping_q, wake_seen_q;
  logic [1:0]      rst_idx_q;
  logic [2:0][2:0] restore_q;
  logic            activity, trigger, int_issue;

  assign activity  = bus.io_wr || bus.io_rd || bus.wake;
  // Only fires with the FSM idle and FIFO empty, so it always coincides with a pick point.
  assign trigger   = !sleeping_q && (idle_q == 24'd0) && !busy && !activity;
  assign int_valid = trigger || (sleeping_q && wake_seen_q);
  assign int_issue = pick_point && int_valid;
  assign sleeping  = sleeping_q;

  always_comb begin
    int_vec = SLEEP_VECTOR;
    if (!trigger) begin
      case (rst_idx_q)
        2'd0:    int_vec = {3'b100, 2'b00, restore_q[0]};
        2'd1:    int_vec = {3'b010, 2'b00, restore_q[1]};
        default: int_vec = {3'b001, 2'b00, restore_q[2]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_q      <= IDLE_CYCLES;
      sleeping_q  <= 1'b0;
      wake_seen_q <= 1'b0;
      rst_idx_q   <= 2'd0;
      restore_q   <= {SHADOW3_RST, SHADOW2_RST, SHADOW1_RST};
    end else begin
      if (activity || busy)    idle_q <= IDLE_CYCLES;
      else if (idle_q != '0)   idle_q <= idle_q - 24'd1;
      if (trigger) begin
        sleeping_q  <= 1'b1;
        wake_seen_q <= 1'b0;
        rst_idx_q   <= 2'd0;
        restore_q   <= shadow_q;
      end else if (sleeping_q) begin
        if (activity) wake_seen_q <= 1'b1;
        if (int_issue) begin
          if (rst_idx_q == 2'd2) begin
            sleeping_q  <= 1'b0;
            wake_seen_q <= 1'b0;
            rst_idx_q   <= 2'd0;
          end else begin
            rst_idx_q <= rst_idx_q + 2'd1;
          end
        end
      end
    end
  end
`else
  logic unused_sleep_cfg;

  assign int_valid        = 1'b0;
  assign int_vec          = 8'h00;
  assign sleeping         = 1'b0;
  assign unused_sleep_cfg = ^{IDLE_CYCLES, bus.wake};
`endif

  assign bus.io_rdata      = rdata_q;
  assign bus.busy          = busy;
  assign bus.err           = err_q;
  assign bus.change        = change_q;
  assign bus.change_vector = vec_q;

endmodule

// File: tb/tb_pmu_cmd_ctrl.sv
// Directed plus random bench for pmu_cmd_ctrl against a command-timeline reference model.
module tb_pmu_cmd_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int          S     = 16;
  localparam logic [7:0]  CMD   = 8'hF0;
  localparam logic [7:0]  STAT  = 8'hF1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmu_cmd_ctrl_if bus ();

  pmu_cmd_ctrl #(
    .CMD_ADDR      (CMD),
    .STAT_ADDR     (STAT),
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (S),
    .IDLE_CYCLES   (24'd12000000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: every accepted command is a record (push edge, pulse edge, byte).
  int         q_push[$];
  int         q_pop[$];
  logic [7:0] q_vec[$];
  int         last_pop;
  logic       m_err;
  logic [2:0] msh[3];
  int         cyc;
  int         n_checks;
  int         n_errors;

  function automatic int fifo_cnt(input int m);
    int c = 0;
    foreach (q_push[i]) if (q_push[i] <= m && q_pop[i] > m) c++;
    return c;
  endfunction

  function automatic logic m_busy(input int m);
    foreach (q_push[i]) if (q_push[i] <= m && m <= q_pop[i] + S) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_change(input int m);
    foreach (q_pop[i]) if (q_pop[i] == m) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_vec(input int m);
    logic [7:0] v = 8'h00;
    foreach (q_pop[i]) if (q_pop[i] <= m) v = q_vec[i];
    return v;
  endfunction

  task automatic model_reset();
    q_push.delete();
    q_pop.delete();
    q_vec.delete();
    last_pop = -1000;
    m_err    = 1'b0;
    msh[0]   = 3'b001;
    msh[1]   = 3'b011;
    msh[2]   = 3'b000;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick(input logic rst, input logic wr, input logic rd, input logic [7:0] addr,
                      input logic [7:0] wd);
    int         n;
    int         c;
    int         p;
    logic [7:0] exp_rd;
    logic       new_err;
    n             = cyc + 1;
    reset         = ~rst;
    bus.io_wr     = wr;
    bus.io_rd     = rd;
    bus.io_addr   = addr;
    bus.io_wdata  = wd;
    bus.wake      = 1'b0;
    exp_rd        = 8'h00;
    if (rst) begin
      model_reset();
    end else begin
      if (rd && addr == STAT) begin
        c = fifo_cnt(n - 1);
        exp_rd = {m_busy(n - 1), c >= DEPTH, c == 0, m_err, 1'b0, (c > 7) ? 3'd7 : 3'(c)};
      end
      foreach (q_pop[i]) begin
        if (q_pop[i] == n - 1) begin
          if (q_vec[i][7]) msh[0] = q_vec[i][2:0];
          if (q_vec[i][6]) msh[1] = q_vec[i][2:0];
          if (q_vec[i][5]) msh[2] = q_vec[i][2:0];
        end
      end
      new_err = 1'b0;
      if (wr && addr == CMD) begin
        if (wd[2:0] > 3'd4) new_err = 1'b1;
        else if (wd[7:5] != 3'b000) begin
          if (fifo_cnt(n - 1) >= DEPTH) new_err = 1'b1;
          else begin
            p = (n + 1 > last_pop + S + 1) ? n + 1 : last_pop + S + 1;
            q_push.push_back(n);
            q_pop.push_back(p);
            q_vec.push_back({wd[7:5], 2'b00, wd[2:0]});
            last_pop = p;
          end
        end
      end
      if (new_err)                  m_err = 1'b1;
      else if (rd && addr == STAT)  m_err = 1'b0;
    end
    @(posedge clk);
    cyc = n;
    @(negedge clk);
    chk("change",   16'(bus.change),        16'(m_change(n)));
    chk("vector",   16'(bus.change_vector), 16'(m_vec(n)));
    chk("busy",     16'(bus.busy),          16'(m_busy(n)));
    chk("err",      16'(bus.err),           16'(m_err));
    chk("io_rdata", 16'(bus.io_rdata),      16'(exp_rd));
    chk("shadow",   16'(dut.shadow_q),      16'({msh[2], msh[1], msh[0]}));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic wr_cmd(input logic [7:0] d);
    tick(1'b0, 1'b1, 1'b0, CMD, d);
  endtask

  task automatic rd_stat();
    tick(1'b0, 1'b0, 1'b1, STAT, 8'h00);
  endtask

  initial begin
    int         e;
    int         r;
    int         sel;
    logic [31:0] rnd;
    logic [7:0] addr;
    logic [7:0] wd;
    cyc      = 0;
    n_checks = 0;
    n_errors = 0;
    model_reset();

    tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(1'b1, 1'b1, 1'b1, CMD, 8'h82);
    idle(3);

    // Single command from idle, then a status read once settled.
    wr_cmd(8'h82);
    idle(S + 4);
    rd_stat();
    idle(2);

    // Fill the FIFO behind an active command; the last write overflows.
    wr_cmd(8'h22);
    repeat (5) wr_cmd(8'h22);
    rd_stat();
    rd_stat();
    idle(5 * (S + 1) + 4);

    // Illegal mode flags err; empty mask is silently dropped.
    wr_cmd(8'hE5);
    idle(2);
    rd_stat();
    wr_cmd(8'h02);
    idle(2);
    rd_stat();
    idle(2);

    // Push lands on the same edge as a pop while two entries are queued.
    wr_cmd(8'h61);
    e = cyc;
    wr_cmd(8'hA3);
    wr_cmd(8'h44);
    while (cyc < e + S + 1) idle(1);
    wr_cmd(8'h30);
    rd_stat();
    idle(4 * (S + 1));

    // Reset mid-settle abandons the queued command.
    wr_cmd(8'h44);
    wr_cmd(8'h23);
    idle(5);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3 * S);
    rd_stat();

    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      sel = int'($urandom_range(0, 3));
      rnd = $urandom;
      addr = (sel == 0) ? STAT : ((sel == 3) ? rnd[15:8] : CMD);
      wd   = rnd[7:0];
      if (rnd[16]) wd[2:0] = {1'b0, rnd[18:17]};
      tick($urandom_range(0, 299) == 0, r < 35, r >= 25 && r < 45, addr, wd);
    end
    idle(6 * (S + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
